// File: rtl/pc_update_unit_pkg.sv
// Shared CPU definitions: exception-sequencer states, branchType encodings and exception causes.
package pc_update_unit_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2,
    LOAD  = 2'd3
  } state_t;

  localparam logic [1:0] BR_EQ = 2'd0;
  localparam logic [1:0] BR_NE = 2'd1;
  localparam logic [1:0] BR_LE = 2'd2;
  localparam logic [1:0] BR_GT = 2'd3;

  localparam logic [1:0] EXC_ALIGN  = 2'd0;
  localparam logic [1:0] EXC_OPCODE = 2'd1;
  localparam logic [1:0] EXC_OVF    = 2'd2;
  localparam logic [1:0] EXC_DIV0   = 2'd3;

endpackage

// File: rtl/branch_cond.sv
// Combinational branch-condition evaluator: selects the ALU-flag condition named by branchType.
module branch_cond
  import pc_update_unit_pkg::*;
(
  input  logic [1:0] branch_type,
  input  logic       zero,
  input  logic       gt,
  output logic       take_c
);

  always_comb begin
    take_c = 1'b0;
    case (branch_type)
      BR_EQ:   take_c = zero;
      BR_NE:   take_c = ~zero;
      BR_LE:   take_c = zero | ~gt;
      BR_GT:   take_c = gt;
      default: take_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_update_unit.sv
// PC/EPC register stage with the multicycle exception-entry sequencer (save EPC, read vector, load PC).
// Optional misaligned-target trap enabled by defining PC_ALIGN_CHECK_EN.
module pc_update_unit
  import pc_update_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned VEC_BASE    = 252,
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pcSourceOut,
  input  logic        pcWrite,
  input  logic        pcWriteCond,
  input  logic [1:0]  branchType,
  input  logic        zero,
  input  logic        gt,
  input  logic        excReq,
  input  logic [1:0]  excCause,
  input  logic [31:0] mdr,
  output logic [31:0] pc,
  output logic [31:0] epc,
  output logic [31:0] excAddr,
  output logic        excMemRead,
  output logic        excBusy
);

  localparam int unsigned CNT_W = 3;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [31:0]      pc_next, epc_next, exc_addr_next;
  logic             mem_read_next, busy_next;
  logic             take_cond_c, write_req_c;
  logic [23:0]      mdr_unused;

  assign mdr_unused = mdr[31:8];

  branch_cond u_branch_cond (
    .branch_type (branchType),
    .zero        (zero),
    .gt          (gt),
    .take_c      (take_cond_c)
  );

  assign write_req_c = pcWrite | (pcWriteCond & take_cond_c);

  // Next-state and next-register values; the vector address is captured on entry to FETCH.
  always_comb begin
    state_next    = state;
    cnt_next      = cnt;
    pc_next       = pc;
    epc_next      = epc;
    exc_addr_next = '0;
    mem_read_next = 1'b0;
    case (state)
      IDLE: begin
        if (excReq) begin
          epc_next      = pc - 32'd4;
          exc_addr_next = 32'(VEC_BASE) + 32'(excCause);
          mem_read_next = 1'b1;
          state_next    = FETCH;
`ifdef PC_ALIGN_CHECK_EN
        end else if (write_req_c && (pcSourceOut[1:0] != 2'b00)) begin
          epc_next      = pc - 32'd4;
          exc_addr_next = 32'(VEC_BASE) + 32'(EXC_ALIGN);
          mem_read_next = 1'b1;
          state_next    = FETCH;
`endif
        end else if (write_req_c) begin
          pc_next = pcSourceOut;
        end
      end
      FETCH: begin
        cnt_next   = CNT_W'(MEM_LATENCY);
        state_next = WAIT;
      end
      WAIT: begin
        if (cnt <= CNT_W'(1)) begin
          cnt_next   = '0;
          state_next = LOAD;
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      LOAD: begin
        pc_next    = {24'b0, mdr[7:0]};
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      pc         <= RESET_PC;
      epc        <= '0;
      excAddr    <= '0;
      excMemRead <= 1'b0;
      excBusy    <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      pc         <= pc_next;
      epc        <= epc_next;
      excAddr    <= exc_addr_next;
      excMemRead <= mem_read_next;
      excBusy    <= busy_next;
    end
  end

endmodule

// File: tb/tb_pc_update_unit.sv
// Directed bench for pc_update_unit: PC write/branch vector table plus exception, reset and alignment sequences.
module tb_pc_update_unit;

  logic        clk;
  logic        reset;
  logic [31:0] pcSourceOut;
  logic        pcWrite;
  logic        pcWriteCond;
  logic [1:0]  branchType;
  logic        zero;
  logic        gt;
  logic        excReq;
  logic [1:0]  excCause;
  logic [31:0] mdr;
  logic [31:0] pc;
  logic [31:0] epc;
  logic [31:0] excAddr;
  logic        excMemRead;
  logic        excBusy;

  int checks = 0;
  int errors = 0;

  pc_update_unit #(
    .RESET_PC    (32'h0000_0100),
    .VEC_BASE    (252),
    .MEM_LATENCY (1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pcSourceOut (pcSourceOut),
    .pcWrite     (pcWrite),
    .pcWriteCond (pcWriteCond),
    .branchType  (branchType),
    .zero        (zero),
    .gt          (gt),
    .excReq      (excReq),
    .excCause    (excCause),
    .mdr         (mdr),
    .pc          (pc),
    .epc         (epc),
    .excAddr     (excAddr),
    .excMemRead  (excMemRead),
    .excBusy     (excBusy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic        wrc;
    logic [1:0]  bt;
    logic        z;
    logic        g;
    logic [31:0] src;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    pcWrite     = 1'b0;
    pcWriteCond = 1'b0;
    branchType  = 2'd0;
    zero        = 1'b0;
    gt          = 1'b0;
    excReq      = 1'b0;
    excCause    = 2'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 32'h104, 32'h104};
    vecs[1]  = '{1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 32'h200, 32'h200};
    vecs[2]  = '{1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 32'h300, 32'h300};
    vecs[3]  = '{1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 32'h200, 32'h300};
    vecs[4]  = '{1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 32'h200, 32'h200};
    vecs[5]  = '{1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 32'h300, 32'h300};
    vecs[6]  = '{1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 32'h200, 32'h300};
    vecs[7]  = '{1'b0, 1'b1, 2'd3, 1'b0, 1'b1, 32'h200, 32'h200};
    vecs[8]  = '{1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 32'h208, 32'h200};
    vecs[9]  = '{1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 32'h208, 32'h208};
    vecs[10] = '{1'b0, 1'b1, 2'd2, 1'b0, 1'b1, 32'h20C, 32'h208};
    vecs[11] = '{1'b0, 1'b1, 2'd2, 1'b1, 1'b1, 32'h20C, 32'h20C};
    vecs[12] = '{1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 32'h400, 32'h20C};
    vecs[13] = '{1'b1, 1'b1, 2'd3, 1'b0, 1'b0, 32'h040, 32'h040};

    idle_inputs();
    pcSourceOut = 32'h0;
    mdr         = 32'h0;
    reset       = 1'b0;
    #12;
    chk("rst_pc", pc, 32'h100);
    chk("rst_epc", epc, 32'h0);
    chk("rst_busy", 32'(excBusy), 32'h0);
    chk("rst_memread", 32'(excMemRead), 32'h0);
    chk("rst_excaddr", excAddr, 32'h0);
    reset = 1'b1;
    tick();
    chk("post_rst_pc", pc, 32'h100);

    // Table of plain and conditional PC writes
    for (int i = 0; i < 14; i++) begin
      pcWrite     = vecs[i].wr;
      pcWriteCond = vecs[i].wrc;
      branchType  = vecs[i].bt;
      zero        = vecs[i].z;
      gt          = vecs[i].g;
      pcSourceOut = vecs[i].src;
      tick();
      chk($sformatf("vec%0d_pc", i), pc, vecs[i].exp_pc);
      chk($sformatf("vec%0d_busy", i), 32'(excBusy), 32'h0);
    end
    idle_inputs();

    // Overflow exception at pc=0x40, competing with pcWrite
    excReq = 1'b1; excCause = 2'd2; pcWrite = 1'b1; pcSourceOut = 32'h500;
    mdr = 32'hFFFF_FF77;
    tick();
    idle_inputs();
    chk("e0_epc", epc, 32'h3C);
    chk("e0_pc", pc, 32'h40);
    chk("e0_memread", 32'(excMemRead), 32'h1);
    chk("e0_excaddr", excAddr, 32'd254);
    chk("e0_busy", 32'(excBusy), 32'h1);
    tick();
    chk("e1_memread", 32'(excMemRead), 32'h0);
    chk("e1_excaddr", excAddr, 32'h0);
    chk("e1_busy", 32'(excBusy), 32'h1);
    chk("e1_pc", pc, 32'h40);
    excReq = 1'b1; excCause = 2'd3; pcWrite = 1'b1; pcSourceOut = 32'h600;
    tick();
    idle_inputs();
    chk("e2_pc", pc, 32'h40);
    chk("e2_epc", epc, 32'h3C);
    chk("e2_busy", 32'(excBusy), 32'h1);
    chk("e2_memread", 32'(excMemRead), 32'h0);
    mdr = 32'h1234_56AB;
    tick();
    chk("e3_pc", pc, 32'hAB);
    chk("e3_epc", epc, 32'h3C);
    chk("e3_busy", 32'(excBusy), 32'h0);
    mdr = 32'h0;
    tick();
    chk("e4_pc", pc, 32'hAB);
    chk("e4_busy", 32'(excBusy), 32'h0);
    chk("e4_memread", 32'(excMemRead), 32'h0);

    // pc=0 wraps epc; reset in WAIT abandons the sequence
    pcWrite = 1'b1; pcSourceOut = 32'h0;
    tick();
    idle_inputs();
    chk("zero_pc", pc, 32'h0);
    excReq = 1'b1; excCause = 2'd3;
    tick();
    idle_inputs();
    chk("wrap_epc", epc, 32'hFFFF_FFFC);
    chk("div0_excaddr", excAddr, 32'd255);
    tick();
    chk("wait_busy", 32'(excBusy), 32'h1);
    reset = 1'b0;
    #1;
    chk("arst_pc", pc, 32'h100);
    chk("arst_epc", epc, 32'h0);
    chk("arst_busy", 32'(excBusy), 32'h0);
    chk("arst_memread", 32'(excMemRead), 32'h0);
    #2;
    reset = 1'b1;
    mdr = 32'h0000_00CC;
    tick();
    tick();
    chk("after_arst_pc", pc, 32'h100);
    chk("after_arst_busy", 32'(excBusy), 32'h0);

    // Misaligned target
    pcWrite = 1'b1; pcSourceOut = 32'h10;
    tick();
    chk("align_setup_pc", pc, 32'h10);
    pcSourceOut = 32'h202;
    tick();
    idle_inputs();
`ifdef PC_ALIGN_CHECK_EN
    chk("align_pc_held", pc, 32'h10);
    chk("align_epc", epc, 32'hC);
    chk("align_excaddr", excAddr, 32'd252);
    chk("align_busy", 32'(excBusy), 32'h1);
    mdr = 32'h0000_0080;
    tick();
    tick();
    tick();
    chk("align_vec_pc", pc, 32'h80);
    chk("align_done_busy", 32'(excBusy), 32'h0);
`else
    chk("noalign_pc", pc, 32'h202);
    chk("noalign_busy", 32'(excBusy), 32'h0);
    chk("noalign_epc", epc, 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
